hub75_rx: RTL

HUB75_RX -- requirements
Module: hub75_rx

---
 rtl/hub75_rx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rx
// Brief    : HUB75 panel-bus receiver. Captures shifted lines and replays each
//            latched line as a ready/valid pixel stream. The optional on-time
//            counter is built only when HUB75_RX_ONTIME_EN is defined.
// Revision : 1.0
// ============================================================================
module hub75_rx #(
    parameter int NUM_COLS = 64,
    parameter int ROW_BITS = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_screen,
    input  logic                        R0,
    input  logic                        G0,
    input  logic                        B0,
    input  logic                        R1,
    input  logic                        G1,
    input  logic                        B1,
    input  logic                        latch,
    input  logic                        blank,
    input  logic [ROW_BITS-1:0]         row,
    output logic                        px_valid,
    input  logic                        px_ready,
    output logic [$clog2(NUM_COLS)-1:0] px_col,
    output logic [ROW_BITS-1:0]         px_row,
    output logic [5:0]                  px_rgb,
    output logic                        overrun,
    output logic [15:0]                 on_cycles,
    output logic                        on_valid
);

    localparam int COL_W = $clog2(NUM_COLS);
    localparam int SW    = 8 + ROW_BITS;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(NUM_COLS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SW-1:0]       w_sync_in;
    logic [SW-1:0]       r_sync1;
    logic [SW-1:0]       r_sync2;
    logic [1:0]          r_sync3;
    logic                w_scr_s;
    logic                w_lat_s;
    logic [ROW_BITS-1:0] w_row_s;
    logic [5:0]          w_rgb_s;
    logic                w_scr_rise;
    logic                w_lat_rise;

    assign w_sync_in = {clk_screen, latch, row, R0, G0, B0, R1, G1, B1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= w_sync_in;
            r_sync2 <= r_sync1;
            r_sync3 <= {r_sync2[SW-1], r_sync2[SW-2]};
        end
    end

    assign w_scr_s    = r_sync2[SW-1];
    assign w_lat_s    = r_sync2[SW-2];
    assign w_row_s    = r_sync2[6 +: ROW_BITS];
    assign w_rgb_s    = r_sync2[5:0];
    assign w_scr_rise = w_scr_s & ~r_sync3[1];
    assign w_lat_rise = w_lat_s & ~r_sync3[0];

    // ------------------------------------------------------------------
    // Shift buffer; a same-cycle latch sees the column written this cycle
    // ------------------------------------------------------------------
    logic [5:0]       r_shift_buf  [NUM_COLS];
    logic [5:0]       w_shift_next [NUM_COLS];
    logic [COL_W-1:0] r_wcol;

    always_comb begin
        w_shift_next = r_shift_buf;
        if (w_scr_rise) begin
            w_shift_next[r_wcol] = w_rgb_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                r_shift_buf[i] <= '0;
            end
            r_wcol <= '0;
        end else begin
            r_shift_buf <= w_shift_next;
            if (w_lat_rise) begin
                r_wcol <= '0;
            end else if (w_scr_rise) begin
                r_wcol <= r_wcol + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line capture and overrun detection
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [5:0]          r_out_buf [NUM_COLS];
    logic [ROW_BITS-1:0] r_px_row;
    logic                r_load;
    logic                r_overrun;
    logic [COL_W-1:0]    r_px_col;
    logic                w_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                r_out_buf[i] <= '0;
            end
            r_px_row  <= '0;
            r_load    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (w_lat_rise) begin
                if (r_state == S_IDLE) begin
                    r_out_buf <= w_shift_next;
                    r_px_row  <= w_row_s;
                    r_load    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stream FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_load) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_hs && (r_px_col == C_LAST_COL)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        px_valid = 1'b0;
        if (r_state == S_STREAM) begin
            px_valid = 1'b1;
        end
    end

    assign w_hs = px_valid & px_ready;

    // Column wraps to 0 naturally after the last handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px_col <= '0;
        end else if (r_load) begin
            r_px_col <= '0;
        end else if (w_hs) begin
            r_px_col <= r_px_col + 1'b1;
        end
    end

    assign px_col  = r_px_col;
    assign px_row  = r_px_row;
    assign px_rgb  = r_out_buf[r_px_col];
    assign overrun = r_overrun;

    // ------------------------------------------------------------------
    // Unblanked on-time measurement
    // ------------------------------------------------------------------
`ifdef HUB75_RX_ONTIME_EN
    logic [1:0]  r_blk_sync;
    logic        r_blk_d;
    logic        w_blk_rise;
    logic [15:0] r_on_cnt;
    logic [15:0] r_on_cycles;
    logic        r_on_valid;

    assign w_blk_rise = r_blk_sync[1] & ~r_blk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_sync  <= '0;
            r_blk_d     <= 1'b0;
            r_on_cnt    <= '0;
            r_on_cycles <= '0;
            r_on_valid  <= 1'b0;
        end else begin
            r_blk_sync <= {r_blk_sync[0], blank};
            r_blk_d    <= r_blk_sync[1];
            r_on_valid <= 1'b0;
            if (w_blk_rise) begin
                r_on_cycles <= r_on_cnt;
                r_on_valid  <= 1'b1;
                r_on_cnt    <= '0;
            end else if (!r_blk_sync[1] && (r_on_cnt != 16'hFFFF)) begin
                r_on_cnt <= r_on_cnt + 16'd1;
            end
        end
    end

    assign on_cycles = r_on_cycles;
    assign on_valid  = r_on_valid;
`else
    logic w_unused_blank;

    assign w_unused_blank = blank;
    assign on_cycles      = '0;
    assign on_valid       = 1'b0;
`endif

endmodule
`default_nettype wire
